// File: rtl/arbitro_mux4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_mux4_pkg
// Brief    : Shared types and helpers for the 4-way round-robin line arbiter.
// Revision : 1.0
// ============================================================================
package arbitro_mux4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational round-robin pick: first set req bit from ptr, wrapping.
// Revision : 1.0
// ============================================================================
module rr_pick4
    import arbitro_mux4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitro_mux4.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_mux4
// Brief    : Round-robin arbiter sequencing a 4:1 select onto a registered line.
// Revision : 1.0
// ============================================================================
module arbitro_mux4
    import arbitro_mux4_pkg::*;
#(
    parameter int unsigned MAX_HOLD  = 4,
    parameter int unsigned PRIO_INIT = 0
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] A,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             B,
    output logic             busy
);

    localparam int unsigned      HOLD_W      = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_max_hold  = HOLD_W'(MAX_HOLD);
    localparam logic [SEL_W-1:0]  c_prio_init = SEL_W'(PRIO_INIT);

    state_t            r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold;

    logic              w_release;
    logic              w_found;
    logic [SEL_W-1:0]  w_next_ptr;
    logic [SEL_W-1:0]  w_pick_ptr;
    logic [SEL_W-1:0]  w_idx;

    assign w_release  = !req[sel] || (r_hold == c_max_hold);
    assign w_next_ptr = sel + SEL_W'(1);
    // In GRANT the search only matters on release, where it starts past the holder.
    assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= c_prio_init;
            r_hold  <= '0;
            sel     <= '0;
            gnt     <= '0;
            B       <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    B <= 1'b0;
                    if (w_found) begin
                        r_state <= GRANT;
                        sel     <= w_idx;
                        gnt     <= onehot(w_idx);
                        r_hold  <= HOLD_W'(1);
                        busy    <= 1'b1;
                    end else begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_found) begin
                            sel    <= w_idx;
                            gnt    <= onehot(w_idx);
                            r_hold <= HOLD_W'(1);
                            B      <= A[sel];
                        end else begin
                            r_state <= IDLE;
                            gnt     <= '0;
                            busy    <= 1'b0;
                            B       <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                        B      <= A[sel];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    B       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_mux4
// Brief    : Self-checking bench for arbitro_mux4 (two parameter sets in parallel).
// Revision : 1.0
// ============================================================================
module tb_arbitro_mux4;

    localparam int MH [2] = '{4, 1};
    localparam int PI [2] = '{0, 2};

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] A;
    logic [1:0] sel_o  [2];
    logic [3:0] gnt_o  [2];
    logic       b_o    [2];
    logic       busy_o [2];

    int total;
    int bad;

    // Reference model: holder index, hold length, priority pointer, line value.
    bit m_busy [2];
    int m_sel  [2];
    int m_hold [2];
    int m_ptr  [2];
    bit m_b    [2];

    arbitro_mux4 #(.MAX_HOLD(4), .PRIO_INIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A),
        .sel(sel_o[0]), .gnt(gnt_o[0]), .B(b_o[0]), .busy(busy_o[0])
    );

    arbitro_mux4 #(.MAX_HOLD(1), .PRIO_INIT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A),
        .sel(sel_o[1]), .gnt(gnt_o[1]), .B(b_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_sel[d]  = 0;
            m_hold[d] = 0;
            m_ptr[d]  = PI[d];
            m_b[d]    = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int idx;
            bit nb;
            if (!m_busy[d]) begin
                m_b[d] = 1'b0;
                idx = pick(req, m_ptr[d]);
                if (idx >= 0) begin
                    m_busy[d] = 1'b1;
                    m_sel[d]  = idx;
                    m_hold[d] = 1;
                end
            end else begin
                nb = A[m_sel[d]];
                if (!req[m_sel[d]] || m_hold[d] == MH[d]) begin
                    m_ptr[d] = (m_sel[d] + 1) % 4;
                    idx = pick(req, m_ptr[d]);
                    if (idx >= 0) begin
                        m_sel[d]  = idx;
                        m_hold[d] = 1;
                        m_b[d]    = nb;
                    end else begin
                        m_busy[d] = 1'b0;
                        m_b[d]    = 1'b0;
                    end
                end else begin
                    m_hold[d] = m_hold[d] + 1;
                    m_b[d]    = nb;
                end
            end
        end
    endtask

    task automatic chk(string tag, int d, logic [3:0] obs, logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%b expected=%b t=%0t", tag, d, obs, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < 2; d++) begin
            logic [3:0] eg;
            eg = m_busy[d] ? (4'b0001 << m_sel[d]) : 4'b0000;
            chk({tag, ":gnt"}, d, gnt_o[d], eg);
            chk({tag, ":sel"}, d, {2'b00, sel_o[d]}, 4'(m_sel[d]));
            chk({tag, ":B"}, d, {3'b000, b_o[d]}, {3'b000, m_b[d]});
            chk({tag, ":busy"}, d, {3'b000, busy_o[d]}, {3'b000, m_busy[d]});
            chk({tag, ":onehot"}, d, {3'b000, ($countones(gnt_o[d]) <= 1)}, 4'b0001);
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        A     = 4'b0000;
        model_reset();
        #1;
        check_all("in_reset");
        #11 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cycle("idle_after_reset");

        req = 4'b0101;
        cycle("p0101");
        chk("p0101_first", 0, gnt_o[0], 4'b0001);
        for (int i = 0; i < 4; i++) cycle("p0101");
        chk("p0101_second", 0, gnt_o[0], 4'b0100);
        chk("p0101_busy", 0, {3'b000, busy_o[0]}, 4'b0001);
        for (int i = 0; i < 7; i++) cycle("p0101");
        req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drain");

        req = 4'b1111;
        for (int i = 0; i < 17; i++) cycle("p1111");
        req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drain");

        req = 4'b1000;
        for (int i = 0; i < 2; i++) cycle("p1000");
        chk("p1000_hold", 0, gnt_o[0], 4'b1000);
        req = 4'b0000;
        cycle("p1000_drop");
        chk("p1000_idle", 0, gnt_o[0], 4'b0000);
        req = 4'b1001;
        cycle("p1001");
        chk("p1001_wrap", 0, gnt_o[0], 4'b0001);
        req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drain");

        A   = 4'b1010;
        req = 4'b0010;
        cycle("line_e1");
        chk("line_sel", 0, {2'b00, sel_o[0]}, 4'd1);
        chk("line_b0", 0, {3'b000, b_o[0]}, 4'b0000);
        cycle("line_e2");
        chk("line_b1", 0, {3'b000, b_o[0]}, 4'b0001);
        A = 4'b1000;
        cycle("line_e3");
        chk("line_flip", 0, {3'b000, b_o[0]}, 4'b0000);

        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_gnt", 0, gnt_o[0], 4'b0000);
        chk("rst_mid_b", 0, {3'b000, b_o[0]}, 4'b0000);
        check_all("rst_mid");
        #2 rst_n = 1'b1;
        req = 4'b0110;
        cycle("after_rst");
        chk("after_rst_first", 0, gnt_o[0], 4'b0010);
        for (int i = 0; i < 3; i++) cycle("after_rst");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            A = 4'($urandom);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
